// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// 8N1 serial receiver: 1 start bit, 8 data bits LSB first, no parity, 1 stop
// bit. Pairs with uart_tx. Each correctly framed byte is presented on rx_data
// together with a one-cycle po_flag pulse. A stop bit sampled low produces a
// one-cycle frame_err pulse and leaves rx_data untouched.
//
// Parameters
//   BAUD_CNT_END  sclk cycles per bit (50 MHz / 9600 baud = 5208), >= 8
//   BAUD_CNT_MID  baud_cnt value at which each bit is sampled (mid-bit)
//
// Ports
//   sclk       in   system clock
//   s_rst      in   asynchronous, active-high reset
//   rs232_rx   in   serial line, idle high, asynchronous to sclk
//   rx_data    out  [7:0] last correctly framed byte
//   po_flag    out  one-cycle pulse: rx_data updated this cycle
//   frame_err  out  one-cycle pulse: stop bit sampled low
//   rx_busy    out  high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int BAUD_CNT_END = 5208,
    parameter int BAUD_CNT_MID = BAUD_CNT_END / 2
) (
    input  logic       sclk,
    input  logic       s_rst,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       po_flag,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(BAUD_CNT_END);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_END - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_CNT_MID);

    // Reject divider settings that leave no room for a mid-bit sample point.
    generate
        if (BAUD_CNT_END < 8) begin : g_bad_baud
            $error("uart_rx: BAUD_CNT_END must be >= 8");
        end
        if (BAUD_CNT_MID >= BAUD_CNT_END) begin : g_bad_mid
            $error("uart_rx: BAUD_CNT_MID must be below BAUD_CNT_END");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic rx_s1;
    logic rx_s2;
    logic rx_s3;
    logic start_edge;

    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             sample;

    // Decoded actions of the current cycle, produced by the next-state logic.
    logic enter_data;
    logic shift_en;
    logic frame_done;
    logic frame_bad;

    // -------------------------------------------------------------------------
    // Input synchronizer and falling-edge detector.
    // rx_s1/rx_s2 form the metastability guard; rx_s3 is only a history bit
    // for edge detection. Flops reset to 1 so that an idle line does not look
    // like a falling edge right after reset.
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours, as real hardware does.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rs232_rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign start_edge = rx_s3 & ~rx_s2;

    // Mid-bit strobe. Gated by state so a stale count in IDLE never fires.
    assign sample = (baud_cnt == CNT_MID) && (state != IDLE);

    // -------------------------------------------------------------------------
    // State register.
    // -------------------------------------------------------------------------
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and action decode.
    // The line is only looked at on the mid-bit sample strobe once a frame has
    // started; there is no resynchronisation mid-frame.
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the case so that
    // no path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        enter_data = 1'b0;
        shift_en   = 1'b0;
        frame_done = 1'b0;
        frame_bad  = 1'b0;

        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_next = START;
                end
            end

            START: begin
                if (sample) begin
                    if (rx_s2) begin
                        // Line already back high at mid start bit: a glitch.
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        enter_data = 1'b1;
                    end
                end
            end

            DATA: begin
                if (sample) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end

            STOP: begin
                if (sample) begin
                    // Leaving at mid stop bit re-arms the edge detector in time
                    // for a start bit that follows the stop bit directly.
                    state_next = IDLE;
                    if (rx_s2) begin
                        frame_done = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Bit-period counter: held at 0 in IDLE (including the cycle a frame is
    // abandoned or completed), free-running 0..BAUD_CNT_END-1 otherwise.
    // -------------------------------------------------------------------------
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            baud_cnt <= '0;
        end else if (state == IDLE || state_next == IDLE) begin
            baud_cnt <= '0;
        end else if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Data path: bit counter and LSB-first shift register.
    // bit_cnt wraps from 7 back to 0 on the last data sample by design.
    // -------------------------------------------------------------------------
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
        end else begin
            if (enter_data) begin
                bit_cnt <= 3'd0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (shift_en) begin
                shift <= {rx_s2, shift[7:1]};
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output registers. frame_done and frame_bad are mutually exclusive, so
    // po_flag and frame_err can never be high together. rx_data only changes
    // on a good stop bit, so it is stable between po_flag pulses.
    // -------------------------------------------------------------------------
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            rx_data   <= 8'h00;
            po_flag   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            po_flag   <= frame_done;
            frame_err <= frame_bad;
            if (frame_done) begin
                rx_data <= shift;
            end
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//
// Scoreboard bench for uart_rx with BAUD_CNT_END = 16 (bit = 320 ns at a
// 20 ns sclk). Stimulus tasks push the expected pulse (byte or framing error)
// into a queue as they start a frame; an independent monitor pops an entry
// whenever po_flag or frame_err is seen and compares it. A small serializer
// stands in for uart_tx in the loopback section.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BAUD = 16;
    localparam int FRAME_CYC = 10 * BAUD;
    localparam int LATENCY = 9 * BAUD + BAUD / 2 + 4;

    logic       sclk;
    logic       s_rst;
    logic       rs232_rx;
    logic [7:0] rx_data;
    logic       po_flag;
    logic       frame_err;
    logic       rx_busy;

    logic drv_rx;
    logic tx_line;
    logic loop_en;

    assign rs232_rx = loop_en ? tx_line : drv_rx;

    uart_rx #(
        .BAUD_CNT_END(BAUD)
    ) dut (
        .sclk     (sclk),
        .s_rst    (s_rst),
        .rs232_rx (rs232_rx),
        .rx_data  (rx_data),
        .po_flag  (po_flag),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    initial sclk = 1'b0;
    always #10 sclk = ~sclk;

    int cyc = 0;
    initial forever begin
        @(posedge sclk);
        cyc = cyc + 1;
    end

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         gap;
        int         lat_start;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] last_byte = 8'h00;
    int last_po = -1;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] req);
        n_checks = n_checks + 1;
        if (ok) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] d, input int gap, input int lat_start);
        exp_t e;
        e.is_err    = 1'b0;
        e.data      = d;
        e.gap       = gap;
        e.lat_start = lat_start;
        exp_q.push_back(e);
        last_byte = d;
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err    = 1'b1;
        e.data      = last_byte;
        e.gap       = 0;
        e.lat_start = -1;
        exp_q.push_back(e);
    endtask

    // Drives one frame on drv_rx. Returns rx_busy sampled mid data bit 4.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                              input int gap, input bit want_lat,
                              output bit busy_mid);
        logic [9:0] frame;
        frame = {stop_ok, d, 1'b0};
        busy_mid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drv_rx = frame[i];
            if (i == 0) begin
                if (stop_ok) push_byte(d, gap, want_lat ? cyc : -1);
                else         push_err();
            end
            for (int k = 0; k < BAUD; k++) begin
                if (i == 5 && k == BAUD / 2) busy_mid = rx_busy;
                @(negedge sclk);
            end
        end
        drv_rx = 1'b1;
    endtask

    // Stand-in for uart_tx: latches a byte on trigger and shifts out a
    // 10-bit frame with its own bit-period counter.
    task automatic loop_tx(input logic [7:0] d, input int gap);
        logic [9:0] tx_shift;
        int         tx_cnt;
        int         tx_bits;
        tx_shift = {1'b1, d, 1'b0};
        tx_cnt   = 0;
        tx_bits  = 0;
        push_byte(d, gap, -1);
        tx_line = tx_shift[0];
        while (tx_bits < 10) begin
            @(negedge sclk);
            if (tx_cnt == BAUD - 1) begin
                tx_cnt   = 0;
                tx_bits  = tx_bits + 1;
                tx_shift = {1'b1, tx_shift[9:1]};
                tx_line  = tx_shift[0];
            end else begin
                tx_cnt = tx_cnt + 1;
            end
        end
        tx_line = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge sclk);
            n = n + 1;
        end
        check(exp_q.size() == 0, name, exp_q.size(), 0);
    endtask

    task automatic idle_check(input string name, input int cycles);
        repeat (cycles) @(negedge sclk);
        check(rx_busy == 1'b0, name, rx_busy, 0);
    endtask

    // Monitor: compares every output pulse against the head of the queue.
    initial forever begin
        exp_t e;
        @(negedge sclk);
        if (!s_rst && (po_flag || frame_err)) begin
            check(!(po_flag && frame_err), "pulse exclusive", {po_flag, frame_err}, 0);
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected pulse", {po_flag, frame_err}, 0);
            end else begin
                e = exp_q.pop_front();
                check(po_flag == !e.is_err, "pulse kind", {po_flag, frame_err},
                      e.is_err ? 32'd1 : 32'd2);
                check(rx_data == e.data, e.is_err ? "rx_data held" : "rx_data",
                      rx_data, e.data);
                if (po_flag && e.gap > 0) begin
                    check((cyc - last_po) >= e.gap - 1 && (cyc - last_po) <= e.gap + 1,
                          "frame spacing", cyc - last_po, e.gap);
                end
                if (po_flag && e.lat_start >= 0) begin
                    check((cyc - e.lat_start) >= LATENCY - 1 &&
                          (cyc - e.lat_start) <= LATENCY + 1,
                          "po_flag latency", cyc - e.lat_start, LATENCY);
                end
            end
            if (po_flag) last_po = cyc;
        end
    end

    initial begin
        bit busy_mid;

        s_rst   = 1'b1;
        drv_rx  = 1'b1;
        tx_line = 1'b1;
        loop_en = 1'b0;
        repeat (3) @(negedge sclk);
        check(rx_data == 8'h00, "reset rx_data", rx_data, 8'h00);
        check(po_flag == 1'b0, "reset po_flag", po_flag, 0);
        check(frame_err == 1'b0, "reset frame_err", frame_err, 0);
        check(rx_busy == 1'b0, "reset rx_busy", rx_busy, 0);
        s_rst = 1'b0;
        repeat (2 * BAUD) @(negedge sclk);

        // 1. Single frame 0x55 with latency and busy checks.
        send_frame(8'h55, 1'b1, 0, 1'b1, busy_mid);
        check(busy_mid == 1'b1, "busy mid-frame", busy_mid, 1);
        idle_check("busy after frame", 2 * BAUD);
        wait_drain("drain single", 4 * FRAME_CYC);

        // 2. Back-to-back 0x7F, 0x80 with no idle gap.
        send_frame(8'h7F, 1'b1, 0, 1'b0, busy_mid);
        send_frame(8'h80, 1'b1, FRAME_CYC, 1'b0, busy_mid);
        idle_check("busy after b2b", 2 * BAUD);
        wait_drain("drain b2b", 4 * FRAME_CYC);

        // 3. 100 ns glitch on an idle line, then a real 0xA5 frame.
        drv_rx = 1'b0;
        repeat (5) @(negedge sclk);
        drv_rx = 1'b1;
        idle_check("busy after glitch", 2 * BAUD);
        send_frame(8'hA5, 1'b1, 0, 1'b0, busy_mid);
        idle_check("busy after A5", 2 * BAUD);
        wait_drain("drain glitch", 4 * FRAME_CYC);

        // 4. Framing error on 0x3C, then a 30-bit break.
        send_frame(8'h3C, 1'b0, 0, 1'b0, busy_mid);
        idle_check("busy after ferr", 2 * BAUD);
        drv_rx = 1'b0;
        push_err();
        repeat (30 * BAUD) @(negedge sclk);
        check(rx_busy == 1'b0, "busy during break", rx_busy, 0);
        drv_rx = 1'b1;
        idle_check("busy after break", 2 * BAUD);
        wait_drain("drain ferr", 4 * FRAME_CYC);

        // 5. Reset during data bit 4 of 0xFF, then 0x12.
        drv_rx = 1'b0;
        repeat (BAUD) @(negedge sclk);
        drv_rx = 1'b1;
        repeat (4 * BAUD + BAUD / 2) @(negedge sclk);
        check(rx_busy == 1'b1, "busy before reset", rx_busy, 1);
        s_rst = 1'b1;
        #1;
        check(rx_data == 8'h00, "mid reset rx_data", rx_data, 8'h00);
        check(rx_busy == 1'b0, "mid reset rx_busy", rx_busy, 0);
        check(po_flag == 1'b0 && frame_err == 1'b0, "mid reset pulses",
              {po_flag, frame_err}, 0);
        last_byte = 8'h00;
        repeat (5) @(negedge sclk);
        s_rst = 1'b0;
        idle_check("busy after reset", 8 * BAUD);
        send_frame(8'h12, 1'b1, 0, 1'b0, busy_mid);
        idle_check("busy after 12", 2 * BAUD);
        wait_drain("drain reset", 4 * FRAME_CYC);

        // 6. Loopback through the serializer model: 0x55 then 0x7F.
        loop_en = 1'b1;
        repeat (BAUD) @(negedge sclk);
        loop_tx(8'h55, 0);
        loop_tx(8'h7F, FRAME_CYC);
        idle_check("busy after loopback", 2 * BAUD);
        wait_drain("drain loopback", 4 * FRAME_CYC);

        repeat (BAUD) @(negedge sclk);
        check(exp_q.size() == 0, "scoreboard empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
